// File: rtl/lpc_cycle_decoder.sv
// ---------------------------------------------------------------------------
// lpc_cycle_decoder
// Passive LPC bus monitor. Follows LFRAME#/LAD[3:0] through the I/O and TPM
// cycle phases and emits one registered record per completed cycle.
//
// Ports
//   clk          LPC clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   lpc_frame_n  LFRAME#, active low
//   lpc_lad      LAD[3:0]
//   cycle_valid  one-clock pulse, record outputs valid while high
//   cycle_write  1 = host write, 0 = read
//   cycle_tpm    1 = TPM start code (0101), 0 = LPC start code (0000)
//   cycle_addr   16-bit cycle address
//   cycle_data   data byte
//   sync_error   one-clock pulse on SYNC error nibble or SYNC wait timeout
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lpc_cycle_decoder #(
  parameter logic [15:0] ADDR_LO      = 16'h0000,
  parameter logic [15:0] ADDR_HI      = 16'hFFFF,
  parameter int          SYNC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lpc_frame_n,
  input  logic [3:0]  lpc_lad,
  output logic        cycle_valid,
  output logic        cycle_write,
  output logic        cycle_tpm,
  output logic [15:0] cycle_addr,
  output logic [7:0]  cycle_data,
  output logic        sync_error
);

  localparam int              WW        = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA} state_t;

  state_t        state_reg, state_next, phase;
  logic [3:0]    start_reg, start_next;
  logic          write_reg, write_next;
  logic [15:0]   addr_reg, addr_next;
  logic [7:0]    data_reg, data_next;
  logic [1:0]    nib_cnt_reg, nib_cnt_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          emit, err, in_range, is_wait;
  logic [16:0]   diff_lo, diff_hi;

  // Range check via borrow bits so the default full-range window does not
  // degenerate into constant comparisons.
  assign diff_lo  = {1'b0, addr_reg} - {1'b0, ADDR_LO};
  assign diff_hi  = {1'b0, ADDR_HI} - {1'b0, addr_reg};
  assign in_range = ~diff_lo[16] & ~diff_hi[16];
  assign is_wait  = (lpc_lad == 4'b0101) || (lpc_lad == 4'b0110);

  // The clock that ends LFRAME# already carries the cycle-type nibble, so the
  // START state with LFRAME# high is decoded as the CYCTYPE phase.
  always_comb begin
    phase = state_reg;
    if (state_reg == START && lpc_frame_n) phase = CYCTYPE;
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      start_reg    <= 4'h0;
      write_reg    <= 1'b0;
      addr_reg     <= 16'h0000;
      data_reg     <= 8'h00;
      nib_cnt_reg  <= 2'd0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= start_next;
      write_reg    <= write_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      nib_cnt_reg  <= nib_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    start_next    = start_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    nib_cnt_next  = nib_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    if (!lpc_frame_n) begin
      // Any LFRAME# low restarts; the last nibble seen while low wins.
      state_next = START;
      start_next = lpc_lad;
    end else begin
      case (phase)
        IDLE: ;
        CYCTYPE: begin
          if ((start_reg == 4'b0000 || start_reg == 4'b0101) && lpc_lad[3:2] == 2'b00) begin
            write_next   = lpc_lad[1];
            nib_cnt_next = 2'd0;
            state_next   = ADDR;
          end else begin
            state_next = IDLE;
          end
        end
        ADDR: begin
          addr_next    = {addr_reg[11:0], lpc_lad};
          nib_cnt_next = nib_cnt_reg + 2'd1;
          if (nib_cnt_reg == 2'd3) state_next = write_reg ? WDATA : TAR1;
        end
        WDATA: begin
          data_next    = {lpc_lad, data_reg[7:4]};   // low nibble arrives first
          nib_cnt_next = nib_cnt_reg + 2'd1;
          if (nib_cnt_reg == 2'd1) begin
            nib_cnt_next = 2'd0;
            state_next   = TAR1;
          end
        end
        TAR1: begin
          nib_cnt_next = nib_cnt_reg + 2'd1;
          if (nib_cnt_reg == 2'd1) begin
            nib_cnt_next  = 2'd0;
            wait_cnt_next = '0;
            state_next    = SYNC;
          end
        end
        SYNC: begin
          if (lpc_lad == 4'b0000) begin
            nib_cnt_next = 2'd0;
            state_next   = write_reg ? IDLE : RDATA;
          end else if (is_wait) begin
            if (wait_cnt_reg == WAIT_LAST) state_next = IDLE;
            else wait_cnt_next = wait_cnt_reg + 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        RDATA: begin
          data_next    = {lpc_lad, data_reg[7:4]};
          nib_cnt_next = nib_cnt_reg + 2'd1;
          if (nib_cnt_reg == 2'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: completion and error events for this clock
  always_comb begin
    emit = 1'b0;
    err  = 1'b0;
    if (lpc_frame_n) begin
      case (phase)
        SYNC: begin
          if (lpc_lad == 4'b0000 && write_reg) emit = in_range;
          if (lpc_lad == 4'b1010) err = 1'b1;
          if (is_wait && wait_cnt_reg == WAIT_LAST) err = 1'b1;
        end
        RDATA: if (nib_cnt_reg == 2'd1) emit = in_range;
        default: ;
      endcase
    end
  end

  // Registered record; fields hold until the next emission
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_valid <= 1'b0;
      sync_error  <= 1'b0;
      cycle_write <= 1'b0;
      cycle_tpm   <= 1'b0;
      cycle_addr  <= 16'h0000;
      cycle_data  <= 8'h00;
    end else begin
      cycle_valid <= emit;
      sync_error  <= err;
      if (emit) begin
        cycle_write <= write_reg;
        cycle_tpm   <= (start_reg == 4'b0101);
        cycle_addr  <= addr_reg;
        cycle_data  <= data_next;
      end
    end
  end

endmodule

// File: doc/lpc_cycle_decoder.md
Name: lpc_cycle_decoder

Overview:
- Passive LPC bus monitor, clocked directly by the LPC clock.
- Tracks LFRAME#/LAD[3:0] through the LPC I/O and TPM cycle phases.
- Emits one registered record per completed cycle: direction, 16-bit address and data byte.
- Sits downstream of the power-on reset generator, which drives `reset`. Feeds the capture FIFO/UART path.

Parameters:
- ADDR_LO, 16'h0000: lowest address reported (inclusive).
- ADDR_HI, 16'hFFFF: highest address reported (inclusive).
- SYNC_TIMEOUT, 16: maximum consecutive wait-state SYNC nibbles before the cycle is aborted.

Ports:
- clk  in  1: LPC clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- lpc_frame_n  in  1: LFRAME#, active low.
- lpc_lad  in  4: LAD[3:0].
- cycle_valid  out  1: one-cycle pulse; record outputs are valid while high.
- cycle_write  out  1: 1 = host write, 0 = read.
- cycle_tpm  out  1: 1 = TPM start code (0101), 0 = LPC start (0000).
- cycle_addr  out  16: cycle address.
- cycle_data  out  8: data byte.
- sync_error  out  1: one-cycle pulse on SYNC error (1010) or SYNC timeout.

Behaviour:
- Reset:
  - state = IDLE.
  - cycle_valid, sync_error, cycle_write, cycle_tpm = 0.
  - cycle_addr = 0, cycle_data = 0.
  - Internal address, data and counters cleared.
  - Reset asserted mid-cycle discards the cycle with no pulse.
- States: IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA.
- Frame handling:
  - When lpc_frame_n = 0 in any state, go to START and latch lpc_lad as the start code.
  - Multi-clock LFRAME#: the start code is the last nibble sampled while low.
  - LFRAME# asserted mid-cycle aborts the cycle silently.
- START to CYCTYPE: the first clock with lpc_frame_n = 1.
  - Start code 0000 or 0101: evaluate CYCTYPE on this clock.
  - Any other start code: go to IDLE.
- CYCTYPE:
  - lad[3:2] must be 00 (I/O). Anything else (memory, DMA) goes to IDLE.
  - lad[1] latches direction (1 = write). lad[0] is ignored.
- ADDR: 4 nibbles, most-significant first, shifted into the address register.
- Write path: ADDR, then WDATA (2 nibbles, low nibble first), then TAR1 (2 clocks, LAD ignored), then SYNC.
- Read path: ADDR, then TAR1 (2 clocks), then SYNC, then RDATA (2 nibbles, low nibble first).
- SYNC:
  - 0000 (ready): a write completes. A read goes to RDATA.
  - 0101 or 0110 (short/long wait): stay in SYNC and increment the wait counter. When the counter reaches SYNC_TIMEOUT, pulse sync_error and go to IDLE.
  - 1010 (error): pulse sync_error the next clock and go to IDLE.
  - Any other nibble: go to IDLE, no pulse.
- Emission:
  - Write: cycle_valid pulses on the clock after the ready SYNC nibble is sampled.
  - Read: cycle_valid pulses on the clock after the second data nibble is sampled.
  - A cycle is emitted only if ADDR_LO <= addr <= ADDR_HI. Out-of-range cycles complete silently.
  - Record outputs hold their values until the next emission.
  - Trailing TAR is not tracked; return to IDLE after emission.
- Back-to-back cycles: LFRAME# low on the clock after emission starts the next cycle normally.

Test Plan:
- TPM write, start 0101, cyctype 0010, addr 0,0,2,4, data 5,A, TAR x2, SYNC 0000 -> one cycle_valid pulse the next clock with write=1, tpm=1, addr=16'h0024, data=8'hA5.
- LPC read, start 0000, cyctype 0000, addr 0x0F00, TAR x2, SYNC 0110 x3 then 0000, data 3,C -> pulse with write=0, tpm=0, addr=16'h0F00, data=8'hC3.
- SYNC 0101 held 16 clocks with SYNC_TIMEOUT=16 -> sync_error pulses once, no cycle_valid; the next valid cycle decodes correctly.
- LFRAME# asserted during the 3rd address nibble, followed by a full write to 0x0024 -> exactly one pulse, for addr=16'h0024.
- ADDR_LO=16'h0020, ADDR_HI=16'h002F: writes to 16'h0024 and then 16'h0080 -> exactly one pulse (16'h0024). Start code 1101 or cyctype 0100 -> no pulse.
- reset asserted during WDATA -> all outputs 0 on the next clock and no pulse. The cycle following reset release decodes normally.
